nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Adds two WIDTH-bit operands one 4-bit nibble per clock by sequencing the team's
//   combinational 4-bit `adder` (ports A, B, Cin -> S, Cout). Sits directly upstream
//   and downstream of that adder: drives its operands, consumes its sum and carry,
//   and registers Cout as the next nibble's Cin.
//   Operands enter through a valid/ready handshake; the result leaves through one.
// PARAMETERS
//   WIDTH    16  operand/result width in bits; must be a multiple of 4 and >= 4
//                (checked at elaboration, $fatal otherwise)
//   NIBBLES  WIDTH/4  localparam, number of adder passes
// PORTS
//   clk        in   1      single clock, all state on posedge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      op_a/op_b/cin valid
//   in_ready   out  1      block can accept an operation (high only in IDLE)
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   cin        in   1      carry-in to nibble 0
//   add_a      out  4      to adder A
//   add_b      out  4      to adder B
//   add_cin    out  1      to adder Cin
//   add_s      in   4      from adder S
//   add_cout   in   1      from adder Cout
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result bits
//   cout       out  1      carry out of top nibble
// BEHAVIOUR
//   - Interface: one clock `clk`; `reset` is synchronous and active-high.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid && in_ready at a posedge: latch op_a and op_b,
//     carry_reg<=cin, idx<=0, sum<=0, go to RUN.
//   - RUN, combinational outputs:
//     add_a   = a_reg[4*idx +: 4]
//     add_b   = b_reg[4*idx +: 4]
//     add_cin = carry_reg
//   - RUN, each posedge: sum[4*idx +: 4]<=add_s, carry_reg<=add_cout, idx<=idx+1.
//     When idx==NIBBLES-1, go to DONE instead of incrementing.
//   - DONE: out_valid=1; sum and cout (=carry_reg) are held stable. On out_ready, go to IDLE.
//   - Latency: out_valid first high exactly NIBBLES clocks after the accepting edge.
//     Throughput is 1 op per NIBBLES+2 clocks minimum.
//   - Outside RUN: add_a=0, add_b=0, add_cin=0.
//   - in_ready=0 in RUN and DONE; in_valid there is ignored and the operands are not resampled.
//   - DONE with out_ready=1 and in_valid=1 in the same cycle: the result is released.
//     The new op is accepted no earlier than the next cycle (in IDLE).
//   - idx width is $clog2(NIBBLES), min 1 bit. WIDTH=4 gives a single RUN cycle.
//   - Carry ripples only through carry_reg; no combinational path from add_cout to add_cin.
//   - Reset values: state=IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0,
//     add_a/add_b/add_cin=0, idx=0. in_valid is ignored while reset is high.
//   - Reset mid-RUN or in DONE: the operation is aborted and its result discarded.
//     out_valid=0 on the next cycle, with no partial result visible.
// TESTING (WIDTH=16, bench instantiates `adder` wired to add_* ports)
//   1. 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0. out_valid rises 4 clocks after accept.
//   2. 0xFFFF+0x0001, cin=0 -> add_cin sequence 0,1,1,1. Result sum=0x0000, cout=1.
//   3. 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Also 0x0000+0x0000, cin=1 -> sum=0x0001, cout=0.
//   4. out_ready low 5 cycles in DONE -> out_valid and sum stay stable. in_valid held high
//      with new operands is not accepted until the cycle after out_ready.
//   5. reset after 2 RUN nibbles -> next cycle out_valid=0, in_ready=1, sum=0.
//      Then 0x00FF+0x0001 -> sum=0x0100, cout=0.
//   6. 200 random ops, random out_ready stalls -> every result matches {cout,sum}=op_a+op_b+cin.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: add two WIDTH-bit operands one nibble per clock by sequencing an external 4-bit adder.
// Latency: out_valid rises NIBBLES clocks after the accepting edge; one op per NIBBLES+2 clocks at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.

// Combinational 4-bit adder stage sequenced by the controller below.
module adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    // Plain 5-bit add split into sum nibble and carry.
    always_comb begin
        {Cout, S} = {1'b0, A} + {1'b0, B} + {4'd0, Cin};
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $fatal(1, "nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;

    // The carry lives only in carry_reg, so there is no comb path add_cout -> add_cin.
    assign sum  = sum_reg;
    assign cout = carry_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus handshake and adder-operand outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx == IDX_W'(n)) begin
                        add_a = a_reg[4*n +: 4];
                        add_b = b_reg[4*n +: 4];
                    end
                end
                add_cin = carry_reg;
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and nibble-by-nibble accumulation of the adder result.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry_reg <= cin;
                        sum_reg   <= '0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) begin
                            sum_reg[4*n +: 4] <= add_s;
                        end
                    end
                    carry_reg <= add_cout;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Purpose: randomized and directed stimulus against an arithmetic reference model.
// Latency: each op is tracked cycle by cycle from accept through release.
// Backpressure: out_ready stalls and in_valid noise are driven while busy.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total;
    int bad;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    adder u_add (.A(add_a), .B(add_b), .Cin(add_cin), .S(add_s), .Cout(add_cout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Carry into nibble k of a+b+c: the carry out of the low 4*k bits.
    function automatic bit carry_into(input logic [15:0] a, input logic [15:0] b,
                                      input logic c, input int k);
        longint unsigned m;
        longint unsigned t;
        m = (64'd1 << (4 * k)) - 64'd1;
        t = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
        return ((t >> (4 * k)) & 64'd1) != 64'd0;
    endfunction

    // Busy-time input activity: 0 quiet, 1 random junk, 2 held valid with other operands.
    task automatic busy_drive(input int mode, input logic [15:0] a);
        if (mode == 1) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = 16'($urandom);
            op_b     = 16'($urandom);
            cin      = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
            in_valid = 1'b1;
            op_a     = ~a;
            op_b     = 16'h1357;
            cin      = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One complete operation; entered and left just after a falling edge in IDLE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input int stall, input int mode);
        logic [16:0] full;
        full = {1'b0, a} + {1'b0, b} + {16'd0, c};
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = c;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        busy_drive(mode, a);
        for (int k = 0; k < NIB; k++) begin
            chk("run_add_a", 32'(add_a), 32'((a >> (4 * k)) & 16'hF));
            chk("run_add_b", 32'(add_b), 32'((b >> (4 * k)) & 16'hF));
            chk("run_add_cin", 32'(add_cin), 32'(carry_into(a, b, c, k)));
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            busy_drive(mode, a);
        end
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_sum", 32'(sum), 32'(full[15:0]));
        chk("done_cout", 32'(cout), 32'(full[16]));
        chk("done_add_a", 32'(add_a), 32'd0);
        chk("done_add_cin", 32'(add_cin), 32'd0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(negedge clk);
            busy_drive(mode, a);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(full[15:0]));
            chk("stall_cout", 32'(cout), 32'(full[16]));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // Still IDLE here: anything presented during DONE must not have been taken.
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        op_a      = 16'hBEEF;
        op_b      = 16'h1111;
        cin       = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        @(negedge clk);

        do_op(16'h1234, 16'h4321, 1'b0, 0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 0);
        do_op(16'hA5C3, 16'h0F0F, 1'b0, 5, 2);

        // Reset after two RUN nibbles aborts the op with nothing visible.
        in_valid = 1'b1;
        op_a = 16'h1234;
        op_b = 16'h1111;
        cin  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        repeat (NIB + 1) @(negedge clk);
        chk("abort_no_done", 32'(out_valid), 32'd0);
        do_op(16'h00FF, 16'h0001, 1'b0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
